cpu_run_ctrl: RTL and testbench

Run/halt/step sequencer for the 8-bit single-cycle CPU. It drives a clock-enable (`cpu_en`) that gates every state element of the core: PC, register bank and RAM write. The enable is controlled by a valid/ready command port (HALT, RUN, STEP N, SET_BP), a PC breakpoint comparator and a saturating executed-cycle counter. It sits between the board debug interface and the CPU top, and watches the CPU's `pc_debug` output.

---
 rtl/cpu_run_ctrl.sv | 146 ++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// Run/halt/step sequencer producing the CPU clock-enable, with PC breakpoint and saturating cycle counter.
// Breakpoint hardware is built only when CPU_RUN_CTRL_BP_EN is defined.
`timescale 1ns/1ps

module cpu_run_ctrl #(
    parameter int PC_W  = 8,
    parameter int CYC_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [1:0]       i_cmd_op,
    input  logic [PC_W:0]    i_cmd_arg,
    input  logic [PC_W-1:0]  i_pc,
    output logic             o_cpu_en,
    output logic             o_halted,
    output logic             o_bp_hit,
    output logic [CYC_W-1:0] o_cycle_count,
    output logic [1:0]       o_state_dbg
);

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    localparam logic [1:0] OP_HALT   = 2'd0;
    localparam logic [1:0] OP_RUN    = 2'd1;
    localparam logic [1:0] OP_STEP   = 2'd2;
    localparam logic [1:0] OP_SET_BP = 2'd3;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PC_W-1:0]  r_step_cnt;
    logic [PC_W-1:0]  w_step_cnt_nxt;
    logic [CYC_W-1:0] r_cycle_count;
    logic             w_accept;
    logic             w_active;
    logic             w_bp_match;
    logic             w_cpu_en;
    logic             w_set_skip;
    logic             w_load_bp;

    // Handshake: a command transfers on a cycle where i_cmd_valid and
    // o_cmd_ready are both high; HALT is always ready, other ops only in HALT.
    assign o_cmd_ready = (r_state == ST_HALT) | (i_cmd_op == OP_HALT);
    assign w_accept    = i_cmd_valid & o_cmd_ready;
    assign w_active    = (r_state == ST_RUN) | (r_state == ST_STEP);
    assign w_cpu_en    = w_active & ~w_bp_match;
    assign w_set_skip  = w_accept & (r_state == ST_HALT) &
                         ((i_cmd_op == OP_RUN) | (i_cmd_op == OP_STEP));
    assign w_load_bp   = w_accept & (r_state == ST_HALT) & (i_cmd_op == OP_SET_BP);

`ifdef CPU_RUN_CTRL_BP_EN
    logic            r_bp_en;
    logic [PC_W-1:0] r_bp_addr;
    logic            r_skip;
    logic            r_bp_hit;

    // skip masks the breakpoint for the first active cycle so a resume
    // executes the instruction the core stopped on.
    assign w_bp_match = r_bp_en & (i_pc == r_bp_addr) & ~r_skip;
    assign o_bp_hit   = r_bp_hit;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bp_en   <= 1'b0;
            r_bp_addr <= '0;
            r_skip    <= 1'b0;
            r_bp_hit  <= 1'b0;
        end else begin
            if (w_load_bp) begin
                r_bp_en   <= i_cmd_arg[PC_W];
                r_bp_addr <= i_cmd_arg[PC_W-1:0];
            end
            if (w_set_skip) begin
                r_skip <= 1'b1;
            end else if (w_active) begin
                r_skip <= 1'b0;
            end
            r_bp_hit <= w_active & w_bp_match;
        end
    end
`else
    logic w_unused_bp;

    assign w_bp_match  = 1'b0;
    assign o_bp_hit    = 1'b0;
    assign w_unused_bp = ^{i_pc, i_cmd_arg[PC_W], w_load_bp};
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_step_cnt_nxt = r_step_cnt;
        case (r_state)
            ST_HALT: begin
                if (w_accept && (i_cmd_op == OP_RUN)) begin
                    w_state_nxt = ST_RUN;
                end else if (w_accept && (i_cmd_op == OP_STEP)) begin
                    w_state_nxt    = ST_STEP;
                    w_step_cnt_nxt = (i_cmd_arg[PC_W-1:0] == '0) ? PC_W'(1)
                                                                 : i_cmd_arg[PC_W-1:0];
                end
            end
            ST_RUN: begin
                // An accepted command outside HALT can only be HALT.
                if (w_bp_match || w_accept) begin
                    w_state_nxt = ST_HALT;
                end
            end
            ST_STEP: begin
                if (w_cpu_en) begin
                    w_step_cnt_nxt = r_step_cnt - PC_W'(1);
                end
                if (w_bp_match || w_accept || (w_cpu_en && (r_step_cnt == PC_W'(1)))) begin
                    w_state_nxt = ST_HALT;
                end
            end
            default: begin
                w_state_nxt = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_HALT;
            r_step_cnt    <= '0;
            r_cycle_count <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_step_cnt <= w_step_cnt_nxt;
            if (w_cpu_en && (r_cycle_count != {CYC_W{1'b1}})) begin
                r_cycle_count <= r_cycle_count + CYC_W'(1);
            end
        end
    end

    assign o_cpu_en      = w_cpu_en;
    assign o_halted      = (r_state == ST_HALT);
    assign o_cycle_count = r_cycle_count;
    assign o_state_dbg   = r_state;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: fixed vector table, hand-built breakpoint/reset sequences and
// randomized commands, all checked against a behavioural model of the run/halt/step rules.
`timescale 1ns/1ps

module tb_cpu_run_ctrl;
    localparam int PC_W    = 8;
    localparam int CYC_W   = 8;
    localparam int CYC_MAX = (1 << CYC_W) - 1;
`ifdef CPU_RUN_CTRL_BP_EN
    localparam bit BP_CFG = 1'b1;
`else
    localparam bit BP_CFG = 1'b0;
`endif

    typedef struct {
        bit             valid;
        logic [1:0]     op;
        logic [PC_W:0]  arg;
        bit             ready;
        bit             en;
        bit             halted;
        bit             hit;
        int             count;
    } vec_t;

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [PC_W:0]    cmd_arg;
    logic [PC_W-1:0]  pc;
    logic             cpu_en;
    logic             halted;
    logic             bp_hit;
    logic [CYC_W-1:0] cycle_count;
    logic [1:0]       state_dbg;

    cpu_run_ctrl #(.PC_W(PC_W), .CYC_W(CYC_W)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_cmd_valid   (cmd_valid),
        .o_cmd_ready   (cmd_ready),
        .i_cmd_op      (cmd_op),
        .i_cmd_arg     (cmd_arg),
        .i_pc          (pc),
        .o_cpu_en      (cpu_en),
        .o_halted      (halted),
        .o_bp_hit      (bp_hit),
        .o_cycle_count (cycle_count),
        .o_state_dbg   (state_dbg)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- model and scoreboard ----------------
    int   n_vec = 0;
    int   n_bad = 0;
    logic [CYC_W+3:0] exp_q[$];

    int m_mode;      // 0 halted, 1 running, 2 stepping
    int m_steps;
    bit m_bp_on;
    int m_bp_pc;
    bit m_skip;
    int m_count;
    bit m_hit;
    bit pc_auto;
    vec_t nov;
    vec_t tab[20];

    function automatic vec_t mk(int v, int op, int arg, int rdy, int en, int hl, int ht, int cnt);
        vec_t r;
        r.valid  = (v != 0);
        r.op     = 2'(op);
        r.arg    = (PC_W+1)'(arg);
        r.ready  = (rdy != 0);
        r.en     = (en != 0);
        r.halted = (hl != 0);
        r.hit    = (ht != 0);
        r.count  = cnt;
        return r;
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_steps = 0;
        m_bp_on = 0;
        m_bp_pc = 0;
        m_skip  = 0;
        m_count = 0;
        m_hit   = 0;
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock: check outputs at the falling edge, advance the model, return at posedge+1.
    task automatic cycle(input string tag, input bit use_tab, input vec_t v);
        bit match, en, e_ready, acc, hit_n;
        int nm;
        logic [CYC_W+3:0] e;
        @(negedge clk);
        match   = BP_CFG && m_bp_on && (int'(pc) == m_bp_pc) && !m_skip;
        en      = (m_mode != 0) && !match;
        e_ready = (m_mode == 0) || (cmd_op == 2'd0);
        exp_q.push_back({e_ready, en, (m_mode == 0), m_hit, CYC_W'(m_count)});
        e = exp_q.pop_front();
        cmp({tag, ".ready"},  32'(cmd_ready),   32'(e[CYC_W+3]));
        cmp({tag, ".en"},     32'(cpu_en),      32'(e[CYC_W+2]));
        cmp({tag, ".halted"}, 32'(halted),      32'(e[CYC_W+1]));
        cmp({tag, ".hit"},    32'(bp_hit),      32'(e[CYC_W]));
        cmp({tag, ".count"},  32'(cycle_count), 32'(e[CYC_W-1:0]));
        if (use_tab) begin
            cmp({tag, ".tab_ready"},  32'(cmd_ready),   32'(v.ready));
            cmp({tag, ".tab_en"},     32'(cpu_en),      32'(v.en));
            cmp({tag, ".tab_halted"}, 32'(halted),      32'(v.halted));
            cmp({tag, ".tab_count"},  32'(cycle_count), 32'(v.count));
        end
        acc   = cmd_valid && e_ready;
        hit_n = (m_mode != 0) && match;
        nm    = m_mode;
        if (en) begin
            m_count = (m_count < CYC_MAX) ? m_count + 1 : CYC_MAX;
            if (m_mode == 2) begin
                m_steps--;
                if (m_steps == 0) nm = 0;
            end
        end
        if (hit_n) nm = 0;
        if (m_mode != 0) m_skip = 0;
        if (acc) begin
            case (cmd_op)
                2'd0: nm = 0;
                2'd1: begin nm = 1; m_skip = 1; end
                2'd2: begin
                    nm      = 2;
                    m_steps = (cmd_arg[PC_W-1:0] == 0) ? 1 : int'(cmd_arg[PC_W-1:0]);
                    m_skip  = 1;
                end
                default: begin
                    m_bp_on = cmd_arg[PC_W];
                    m_bp_pc = int'(cmd_arg[PC_W-1:0]);
                end
            endcase
        end
        m_mode = nm;
        m_hit  = hit_n;
        @(posedge clk);
        #1;
        if (pc_auto && en) pc = pc + 1'b1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input bit v, input int op, input int arg);
        cmd_valid = v;
        cmd_op    = 2'(op);
        cmd_arg   = (PC_W+1)'(arg);
    endtask

    task automatic send(input string tag, input int op, input int arg);
        drive(1'b1, op, arg);
        cycle(tag, 1'b0, nov);
        drive(1'b0, 0, 0);
    endtask

    task automatic idle(input string tag, input int n);
        drive(1'b0, 0, 0);
        for (int i = 0; i < n; i++) cycle(tag, 1'b0, nov);
    endtask

    // ---------------- test ----------------
    initial begin
        tab[0]  = mk(0, 0, 0,      1, 0, 1, 0, 0);
        tab[1]  = mk(1, 2, 3,      1, 0, 1, 0, 0);
        tab[2]  = mk(0, 1, 0,      0, 1, 0, 0, 0);
        tab[3]  = mk(0, 0, 0,      1, 1, 0, 0, 1);
        tab[4]  = mk(0, 0, 0,      1, 1, 0, 0, 2);
        tab[5]  = mk(0, 0, 0,      1, 0, 1, 0, 3);
        tab[6]  = mk(1, 2, 0,      1, 0, 1, 0, 3);
        tab[7]  = mk(0, 0, 0,      1, 1, 0, 0, 3);
        tab[8]  = mk(0, 0, 0,      1, 0, 1, 0, 4);
        tab[9]  = mk(1, 0, 0,      1, 0, 1, 0, 4);
        tab[10] = mk(1, 1, 0,      1, 0, 1, 0, 4);
        tab[11] = mk(1, 1, 0,      0, 1, 0, 0, 4);
        tab[12] = mk(1, 1, 0,      0, 1, 0, 0, 5);
        tab[13] = mk(1, 3, 'h105,  0, 1, 0, 0, 6);
        tab[14] = mk(1, 0, 0,      1, 1, 0, 0, 7);
        tab[15] = mk(0, 0, 0,      1, 0, 1, 0, 8);
        tab[16] = mk(1, 2, 2,      1, 0, 1, 0, 8);
        tab[17] = mk(0, 0, 0,      1, 1, 0, 0, 8);
        tab[18] = mk(1, 0, 0,      1, 1, 0, 0, 9);
        tab[19] = mk(0, 0, 0,      1, 0, 1, 0, 10);
        nov = mk(0, 0, 0, 0, 0, 0, 0, 0);

        rst_n   = 1'b0;
        pc      = '0;
        pc_auto = 1'b0;
        drive(1'b0, 0, 0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        idle("reset_idle", 20);

        for (int i = 0; i < 20; i++) begin
            drive(tab[i].valid, int'(tab[i].op), int'(tab[i].arg));
            cycle($sformatf("tab%0d", i), 1'b1, tab[i]);
        end
        drive(1'b0, 0, 0);

        // Breakpoint at 5 with pc following the core, then resume past it.
        send("setbp5", 3, 'h105);
        pc      = '0;
        pc_auto = 1'b1;
        send("run1", 1, 0);
        idle("run1_body", 14);
        send("run2", 1, 0);
        idle("run2_body", 5);
        send("run2_halt", 0, 0);
        idle("run2_after", 2);

        // HALT issued in the same cycle the breakpoint matches.
        send("setbp_co", 3, 32'h100 | (int'(pc) + 2));
        send("run_co", 1, 0);
        idle("run_co_body", 2);
        send("halt_co", 0, 0);
        idle("co_after", 4);

        // Reset asserted in the middle of a long STEP.
        send("setbp20", 3, 'h120);
        pc = 8'h10;
        send("step200", 2, 200);
        idle("step200_body", 6);
        cmp("pre_rst_en", 32'(cpu_en), 32'd1);
        rst_n = 1'b0;
        #1;
        cmp("rst_async_en",     32'(cpu_en),      32'd0);
        cmp("rst_async_halted", 32'(halted),      32'd1);
        cmp("rst_async_count",  32'(cycle_count), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        pc_auto = 1'b0;
        pc      = 8'h20;
        idle("post_rst", 2);
        send("post_rst_run", 1, 0);
        idle("post_rst_body", 4);
        send("post_rst_halt", 0, 0);
        idle("post_rst_after", 2);

        // Random commands and pc values.
        for (int i = 0; i < 500; i++) begin
            cmd_valid = ($urandom_range(0, 3) == 0);
            cmd_op    = 2'($urandom_range(0, 3));
            cmd_arg   = {1'($urandom_range(0, 1)), 8'($urandom_range(0, 7))};
            pc        = 8'($urandom_range(0, 7));
            cycle("rnd", 1'b0, nov);
        end
        drive(1'b0, 0, 0);
        send("rnd_halt", 0, 0);

        // Long free run to drive the counter into saturation.
        send("sat_bp_off", 3, 0);
        send("sat_run", 1, 0);
        idle("sat_body", 270);
        send("sat_halt", 0, 0);
        idle("sat_after", 2);
        cmp("sat_final", 32'(cycle_count), 32'(CYC_MAX));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
